bbox_tracker: RTL and testbench
===============================

Name: bbox_tracker

Overview:
- Per-frame bounding-box extractor sitting directly upstream of the rectangle overlay stage.
- Consumes a stream of thresholded pixel-mask samples tagged with (x, y) coordinates.
- Accumulates min/max x and y of set pixels over one frame.
- At frame end, publishes two corner points already formatted for the overlay: top-left inclusive, bottom-right exclusive. Optional exponential smoothing and a minimum-pixel validity gate are applied before publishing.

Parameters:
- H_ACTIVE, 1280, active width; samples with x_in >= H_ACTIVE are ignored.
- V_ACTIVE, 720, active height; samples with y_in >= V_ACTIVE are ignored.
- MIN_PIXELS, 64, minimum set-pixel count per frame for a box to be valid.
- SMOOTH_SHIFT, 2, IIR shift (0..4); 0 = publish raw measurement.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous reset, active-high
- x_in  input  11  sample x coordinate
- y_in  input  10  sample y coordinate
- valid_in  input  1  sample qualifier
- mask_in  input  1  sample is a detected pixel (only meaningful with valid_in)
- frame_done_in  input  1  one-cycle pulse: previous sample was the frame's last
- x_out_1  output  11  box left, inclusive
- y_out_1  output  10  box top, inclusive
- x_out_2  output  11  box right, exclusive (max_x+1)
- y_out_2  output  10  box bottom, exclusive (max_y+1)
- box_valid_out  output  1  published box is valid
- pixel_count_out  output  21  set-pixel count of last completed frame
- box_update_out  output  1  one-cycle pulse when outputs are refreshed

Behaviour:
- Reset: all outputs 0, FSM in ACCUM, count = 0, min_x = 2047, min_y = 1023, max_x = 0, max_y = 0. Reset mid-frame discards the partial frame.
- Counted sample: valid_in && mask_in && x_in < H_ACTIVE && y_in < V_ACTIVE.
- Each counted sample updates min/max registers and increments count. Count saturates at 2^21-1.
- ACCUM state:
  - frame_done_in high → snapshot min/max/count into measurement regs.
  - Reload accumulators to their reset values.
  - Go to PUBLISH.
  - A counted sample in the same cycle as frame_done_in belongs to the ending frame and is included in the snapshot.
- PUBLISH state (exactly one cycle), then return to ACCUM:
  - A sample arriving here counts toward the new frame.
  - frame_done_in arriving here is ignored.
- Publish rules:
  - pixel_count_out = snapshot count, always.
  - If count < MIN_PIXELS: box_valid_out = 0 and corner outputs hold their previous values.
  - Else if box_valid_out was 0 or SMOOTH_SHIFT == 0: corners load the raw measurement: x_out_1 = min_x, y_out_1 = min_y, x_out_2 = max_x+1, y_out_2 = max_y+1. Then box_valid_out = 1.
  - Else each corner c is updated as c = c + ((m - c) >>> SMOOTH_SHIFT), where m is the measured value. The difference is signed, 12 bits for x and 11 bits for y; the shift is arithmetic and truncates toward negative infinity. Then box_valid_out = 1.
  - box_update_out pulses high for one cycle on every publish, whether the box is valid or invalid.
- Latency: frame_done_in is sampled at edge N. New outputs and box_update_out are visible after edge N+1 and stay stable until the next publish.
- Width rules: max_x+1 ≤ H_ACTIVE ≤ 2047 cannot overflow 11 bits; same for y within 10 bits. Smoothed results stay within [0, H_ACTIVE] and [0, V_ACTIVE] by construction; no clamping is required.
- Empty frame: count = 0, so the box is invalid and the corners are held.
- Single pixel at (x, y): box = (x, y)-(x+1, y+1).
- Back-to-back frame_done_in pulses on consecutive cycles: only the first is honoured; the second lands in PUBLISH and is dropped.
- Outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset, then frame with mask set for x 100..199, y 50..149 (10000 px); SMOOTH_SHIFT = 2; frame_done:
  - → 2 cycles later box (100,50)-(200,150), valid = 1, count = 10000, one update pulse.
- Second frame with box x 200..299, y 50..149:
  - → x_out_1 = 100+((200-100)>>>2) = 125, x_out_2 = 225, y unchanged, valid = 1.
- Frame with only 10 set pixels (MIN_PIXELS = 64):
  - → valid = 0, corners hold previous values, count = 10, update pulse.
- Next frame after the invalid one, with box x 0..9, y 0..9:
  - → raw load (0,0)-(10,10), no smoothing.
- Counted sample on the same cycle as frame_done_in at (1279,719); sample in PUBLISH cycle at (5,5):
  - → the first is included (x_out_2 = 1280, y_out_2 = 720); the second appears only in the next frame.
- Out-of-range sample (1300,10) plus rst_in pulsed mid-frame:
  - → the out-of-range sample is never counted; after reset all outputs are 0 and the partial frame is discarded.

Source files
------------

// File: rtl/bbox_tracker_if.sv
// Sample stream into the bounding-box tracker and the published box coming out of it.
// Latency: n/a (signal bundle only).
// Backpressure: none; the sample stream is qualified by valid_in and is never stalled.
//
// Sample side : x_in, y_in, valid_in, mask_in, frame_done_in   (driven by the master)
// Result side : x_out_1, y_out_1, x_out_2, y_out_2, box_valid_out,
//               pixel_count_out, box_update_out                   (driven by the slave)
interface bbox_tracker_if;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        valid_in;
    logic        mask_in;
    logic        frame_done_in;

    logic [10:0] x_out_1;
    logic [9:0]  y_out_1;
    logic [10:0] x_out_2;
    logic [9:0]  y_out_2;
    logic        box_valid_out;
    logic [20:0] pixel_count_out;
    logic        box_update_out;

    modport master (
        output x_in, y_in, valid_in, mask_in, frame_done_in,
        input  x_out_1, y_out_1, x_out_2, y_out_2, box_valid_out,
               pixel_count_out, box_update_out
    );

    modport slave (
        input  x_in, y_in, valid_in, mask_in, frame_done_in,
        output x_out_1, y_out_1, x_out_2, y_out_2, box_valid_out,
               pixel_count_out, box_update_out
    );
endinterface

// File: rtl/bbox_tracker.sv
// Per-frame bounding box of set mask pixels, smoothed and gated, formatted for the overlay.
// Latency: frame_done_in sampled at edge N -> new box and box_update_out visible after edge N+1.
// Backpressure: none; every sample is consumed on the cycle it is presented.
//
// Ports: clk_in / rst_in (synchronous, active-high) are plain scalars.
//        bus (bbox_tracker_if.slave) carries the tagged sample stream in and the
//        published box (corners, valid, pixel count, update pulse) out. All outputs registered.
module bbox_tracker #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int MIN_PIXELS   = 64,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    bbox_tracker_if.slave bus
);

    localparam logic [10:0] X_LIM      = 11'(H_ACTIVE);
    localparam logic [9:0]  Y_LIM      = 10'(V_ACTIVE);
    localparam logic [20:0] CNT_MIN    = 21'(MIN_PIXELS);
    localparam logic [20:0] CNT_MAX    = '1;
    localparam logic [10:0] MIN_X_INIT = '1;
    localparam logic [9:0]  MIN_Y_INIT = '1;

    typedef enum logic {
        ACCUM   = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Running accumulators for the frame in progress.
    logic [10:0] acc_min_x, acc_max_x;
    logic [9:0]  acc_min_y, acc_max_y;
    logic [20:0] acc_cnt;

    // Accumulators with the current sample folded in.
    logic [10:0] mrg_min_x, mrg_max_x;
    logic [9:0]  mrg_min_y, mrg_max_y;
    logic [20:0] mrg_cnt;

    // Snapshot of the frame that just ended.
    logic [10:0] meas_min_x, meas_max_x;
    logic [9:0]  meas_min_y, meas_max_y;
    logic [20:0] meas_cnt;

    // Published result registers.
    logic [10:0] x1_q, x2_q;
    logic [9:0]  y1_q, y2_q;
    logic        valid_q;
    logic [20:0] cnt_q;
    logic        upd_q;

    logic        counted;
    logic        take_snap;
    logic        do_publish;

    logic [10:0] m_x1, m_x2;
    logic [9:0]  m_y1, m_y2;

    assign counted = bus.valid_in && bus.mask_in &&
                     (bus.x_in < X_LIM) && (bus.y_in < Y_LIM);

    // c + ((m - c) >>> SMOOTH_SHIFT) using a one-bit-wider signed difference.
    // The sum is taken modulo the output width; it always lands between c and m.
    function automatic logic [10:0] smooth_x(input logic [10:0] c, input logic [10:0] m);
        logic signed [11:0] d;
        d = $signed({1'b0, m}) - $signed({1'b0, c});
        d = d >>> SMOOTH_SHIFT;
        return c + d[10:0];
    endfunction

    function automatic logic [9:0] smooth_y(input logic [9:0] c, input logic [9:0] m);
        logic signed [10:0] d;
        d = $signed({1'b0, m}) - $signed({1'b0, c});
        d = d >>> SMOOTH_SHIFT;
        return c + d[9:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_snap  = 1'b0;
        do_publish = 1'b0;
        case (state)
            ACCUM: begin
                if (bus.frame_done_in) begin
                    take_snap = 1'b1;
                    state_nxt = PUBLISH;
                end
            end
            PUBLISH: begin
                // A frame_done here is deliberately ignored.
                do_publish = 1'b1;
                state_nxt  = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // ---------------- accumulation ----------------
    always_comb begin
        mrg_min_x = acc_min_x;
        mrg_max_x = acc_max_x;
        mrg_min_y = acc_min_y;
        mrg_max_y = acc_max_y;
        mrg_cnt   = acc_cnt;
        if (counted) begin
            if (bus.x_in < acc_min_x) mrg_min_x = bus.x_in;
            if (bus.x_in > acc_max_x) mrg_max_x = bus.x_in;
            if (bus.y_in < acc_min_y) mrg_min_y = bus.y_in;
            if (bus.y_in > acc_max_y) mrg_max_y = bus.y_in;
            if (acc_cnt != CNT_MAX)   mrg_cnt   = acc_cnt + 21'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || take_snap) begin
            // On frame end the same-cycle sample goes to the snapshot (below),
            // so the accumulators restart clean for the next frame.
            acc_min_x <= MIN_X_INIT;
            acc_min_y <= MIN_Y_INIT;
            acc_max_x <= '0;
            acc_max_y <= '0;
            acc_cnt   <= '0;
        end else begin
            acc_min_x <= mrg_min_x;
            acc_min_y <= mrg_min_y;
            acc_max_x <= mrg_max_x;
            acc_max_y <= mrg_max_y;
            acc_cnt   <= mrg_cnt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meas_min_x <= MIN_X_INIT;
            meas_min_y <= MIN_Y_INIT;
            meas_max_x <= '0;
            meas_max_y <= '0;
            meas_cnt   <= '0;
        end else if (take_snap) begin
            meas_min_x <= mrg_min_x;
            meas_min_y <= mrg_min_y;
            meas_max_x <= mrg_max_x;
            meas_max_y <= mrg_max_y;
            meas_cnt   <= mrg_cnt;
        end
    end

    // ---------------- publish ----------------
    // Bottom-right is exclusive; max+1 cannot overflow since max < active size.
    assign m_x1 = meas_min_x;
    assign m_y1 = meas_min_y;
    assign m_x2 = meas_max_x + 11'd1;
    assign m_y2 = meas_max_y + 10'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= do_publish;
            if (do_publish) begin
                cnt_q <= meas_cnt;
                if (meas_cnt < CNT_MIN) begin
                    // Too few pixels: flag invalid, keep the last good corners.
                    valid_q <= 1'b0;
                end else begin
                    if (!valid_q || (SMOOTH_SHIFT == 0)) begin
                        x1_q <= m_x1;
                        y1_q <= m_y1;
                        x2_q <= m_x2;
                        y2_q <= m_y2;
                    end else begin
                        x1_q <= smooth_x(x1_q, m_x1);
                        y1_q <= smooth_y(y1_q, m_y1);
                        x2_q <= smooth_x(x2_q, m_x2);
                        y2_q <= smooth_y(y2_q, m_y2);
                    end
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.x_out_1         = x1_q;
    assign bus.y_out_1         = y1_q;
    assign bus.x_out_2         = x2_q;
    assign bus.y_out_2         = y2_q;
    assign bus.box_valid_out   = valid_q;
    assign bus.pixel_count_out = cnt_q;
    assign bus.box_update_out  = upd_q;

endmodule

// File: tb/tb_bbox_tracker.sv
// Bench for bbox_tracker: directed frame table, hand-written corner sequences and
// randomized frames, all checked every cycle against a queue-based reference model.
module tb_bbox_tracker;

    localparam int H  = 1280;
    localparam int V  = 720;
    localparam int MP = 64;
    localparam int SS = 2;
    localparam int CNT_SAT = 2097151;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bbox_tracker_if bif ();

    bbox_tracker #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .MIN_PIXELS  (MP),
        .SMOOTH_SHIFT(SS)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bif.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int x;
        int y;
    } pt_t;

    pt_t cur[$];
    pt_t snap[$];
    bit  pub_pending = 0;
    int  exp_c[4];
    int  exp_valid = 0;
    int  exp_cnt   = 0;
    int  exp_upd   = 0;

    function automatic int floor_div_pow2(int d, int s);
        int q;
        q = 1 << s;
        if (d >= 0) return d / q;
        return -((-d + q - 1) / q);
    endfunction

    task automatic model_publish();
        int n, mnx, mny, mxx, mxy;
        int m[4];
        n = snap.size();
        exp_cnt = (n > CNT_SAT) ? CNT_SAT : n;
        if (n < MP) begin
            exp_valid = 0;
        end else begin
            mnx = 1 << 30; mny = 1 << 30; mxx = -1; mxy = -1;
            foreach (snap[i]) begin
                if (snap[i].x < mnx) mnx = snap[i].x;
                if (snap[i].x > mxx) mxx = snap[i].x;
                if (snap[i].y < mny) mny = snap[i].y;
                if (snap[i].y > mxy) mxy = snap[i].y;
            end
            m[0] = mnx; m[1] = mny; m[2] = mxx + 1; m[3] = mxy + 1;
            for (int i = 0; i < 4; i++) begin
                if (exp_valid == 0 || SS == 0) exp_c[i] = m[i];
                else exp_c[i] = exp_c[i] + floor_div_pow2(m[i] - exp_c[i], SS);
            end
            exp_valid = 1;
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit mk, input int x, input int y,
                              input bit fd);
        bit was_pub;
        pt_t p;
        if (r) begin
            cur.delete();
            snap.delete();
            pub_pending = 0;
            for (int i = 0; i < 4; i++) exp_c[i] = 0;
            exp_valid = 0; exp_cnt = 0; exp_upd = 0;
            return;
        end
        was_pub = pub_pending;
        if (v && mk && x < H && y < V) begin
            p.x = x; p.y = y;
            cur.push_back(p);
        end
        if (was_pub) begin
            model_publish();
            exp_upd = 1;
            pub_pending = 0;
        end else begin
            exp_upd = 0;
        end
        if (!was_pub && fd) begin
            snap = cur;
            cur.delete();
            pub_pending = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic cmp_all();
        total++;
        if (int'(bif.x_out_1) != exp_c[0] || int'(bif.y_out_1) != exp_c[1] ||
            int'(bif.x_out_2) != exp_c[2] || int'(bif.y_out_2) != exp_c[3] ||
            int'(bif.box_valid_out) != exp_valid || int'(bif.pixel_count_out) != exp_cnt ||
            int'(bif.box_update_out) != exp_upd) begin
            bad++;
            $display("FAIL model cyc=%0d got (%0d,%0d)-(%0d,%0d) v=%0d n=%0d u=%0d want (%0d,%0d)-(%0d,%0d) v=%0d n=%0d u=%0d",
                     cyc, bif.x_out_1, bif.y_out_1, bif.x_out_2, bif.y_out_2, bif.box_valid_out,
                     bif.pixel_count_out, bif.box_update_out, exp_c[0], exp_c[1], exp_c[2],
                     exp_c[3], exp_valid, exp_cnt, exp_upd);
        end
    endtask

    task automatic check(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic check_box(input string nm, input int x1, input int y1, input int x2,
                             input int y2, input int vld, input int cnt, input int upd);
        check({nm, ".x1"},  int'(bif.x_out_1), x1);
        check({nm, ".y1"},  int'(bif.y_out_1), y1);
        check({nm, ".x2"},  int'(bif.x_out_2), x2);
        check({nm, ".y2"},  int'(bif.y_out_2), y2);
        check({nm, ".vld"}, int'(bif.box_valid_out), vld);
        check({nm, ".cnt"}, int'(bif.pixel_count_out), cnt);
        check({nm, ".upd"}, int'(bif.box_update_out), upd);
    endtask

    // One clock: drive inputs, take the edge, update the model, compare #1 later.
    task automatic step(input bit r, input bit v, input bit mk, input int x, input int y,
                        input bit fd);
        rst               = r;
        bif.valid_in      = v;
        bif.mask_in       = mk;
        bif.x_in          = 11'(x);
        bif.y_in          = 10'(y);
        bif.frame_done_in = fd;
        @(posedge clk);
        model_edge(r, v, mk, x, y, fd);
        #1;
        cyc++;
        cmp_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_rect(input int xl, input int xh, input int yl, input int yh);
        for (int yy = yl; yy <= yh; yy++)
            for (int xx = xl; xx <= xh; xx++)
                step(0, 1, 1, xx, yy, 0);
    endtask

    // ---------------- directed frame table ----------------
    typedef struct {
        int xl, xh, yl, yh;
        int ex1, ey1, ex2, ey2, ev, ecnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bx, by, x, y;
        bit v, mk;

        vecs[0] = '{xl: 100, xh: 199, yl: 50, yh: 149,
                    ex1: 100, ey1: 50, ex2: 200, ey2: 150, ev: 1, ecnt: 10000};
        vecs[1] = '{xl: 200, xh: 299, yl: 50, yh: 149,
                    ex1: 125, ey1: 50, ex2: 225, ey2: 150, ev: 1, ecnt: 10000};
        vecs[2] = '{xl: 0, xh: 9, yl: 0, yh: 0,
                    ex1: 125, ey1: 50, ex2: 225, ey2: 150, ev: 0, ecnt: 10};
        vecs[3] = '{xl: 0, xh: 9, yl: 0, yh: 9,
                    ex1: 0, ey1: 0, ex2: 10, ey2: 10, ev: 1, ecnt: 100};

        // Reset
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        idle();
        check_box("reset", 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            send_rect(vecs[i].xl, vecs[i].xh, vecs[i].yl, vecs[i].yh);
            step(0, 0, 0, 0, 0, 1);
            idle();
            check_box($sformatf("row%0d", i), vecs[i].ex1, vecs[i].ey1, vecs[i].ex2,
                      vecs[i].ey2, vecs[i].ev, vecs[i].ecnt, 1);
            idle();
            check($sformatf("row%0d.pulse_end", i), int'(bif.box_update_out), 0);
        end

        // Empty frame: invalid, corners held.
        step(0, 0, 0, 0, 0, 1);
        idle();
        check_box("empty", 0, 0, 10, 10, 0, 0, 1);

        // Sample on the frame_done cycle is included; sample in the publish cycle is not.
        send_rect(0, 63, 0, 0);
        step(0, 1, 1, 1279, 719, 1);
        step(0, 1, 1, 5, 5, 0);
        check_box("edge_sample", 0, 0, 1280, 720, 1, 65, 1);
        step(0, 0, 0, 0, 0, 1);
        idle();
        check_box("publish_sample", 0, 0, 1280, 720, 0, 1, 1);

        // Back-to-back frame_done: second one dropped.
        send_rect(0, 69, 3, 3);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check_box("b2b_first", 0, 3, 70, 4, 1, 70, 1);
        idle();
        check("b2b_second_dropped", int'(bif.box_update_out), 0);

        // One pixel below the gate.
        send_rect(300, 362, 20, 20);
        step(0, 0, 0, 0, 0, 1);
        idle();
        check_box("min_minus1", 0, 3, 70, 4, 0, 63, 1);

        // Out-of-range samples and reset mid-frame.
        send_rect(400, 409, 30, 31);
        step(0, 1, 1, 1300, 10, 0);
        step(0, 1, 1, 10, 720, 0);
        step(1, 0, 0, 0, 0, 0);
        check_box("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        send_rect(10, 73, 7, 7);
        step(0, 1, 1, 1300, 10, 0);
        step(0, 1, 1, 10, 720, 0);
        step(0, 0, 0, 0, 0, 1);
        idle();
        check_box("after_reset", 10, 7, 74, 8, 1, 64, 1);

        // Single pixel frames land around the gate only via random below; here exact single pixel.
        for (int i = 0; i < 63; i++) step(0, 1, 1, 600, 300, 0);
        step(0, 1, 1, 600, 300, 1);
        idle();
        check("single_px.cnt", int'(bif.pixel_count_out), 64);

        // Randomized frames checked against the model every cycle.
        for (int f = 0; f < 60; f++) begin
            n  = $urandom_range(20, 160);
            bx = $urandom_range(0, 1200);
            by = $urandom_range(0, 680);
            for (int c = 0; c < n; c++) begin
                v  = ($urandom_range(0, 3) != 0);
                mk = ($urandom_range(0, 2) != 0);
                x  = bx + $urandom_range(0, 79);
                y  = by + $urandom_range(0, 79);
                if ($urandom_range(0, 15) == 0) x = $urandom_range(1280, 2047);
                if ($urandom_range(0, 15) == 0) y = $urandom_range(720, 1023);
                step(($urandom_range(0, 400) == 0), v, mk, x, y, (c == n - 1));
            end
            if ($urandom_range(0, 4) == 0) step(0, 1, 1, bx, by, 1);
            idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
